sar_search: RTL and testbench

Sequential successive-approximation search engine that drives the `a` operand of a `comparator` instance and consumes its `gt`/`lt`/`eq` outputs to find the hidden value on the `b` operand. It resolves one bit per accepted comparison, MSB first, and supports both signed and unsigned ranges to match the comparator's `SIGNED` mode. It sits between the comparator and any controller needing threshold or code extraction, e.g. SAR ADC trim or value recovery.

---
 rtl/sar_search.sv | 219 +++++++++++++++++++++
 tb/tb_sar_search.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search: successive-approximation search engine.
// Drives the `a` operand of an external comparator with trial values and
// uses its gt/lt/eq answers to recover the hidden `b` value, MSB first.
// The search runs on an unsigned code; the signed range is handled by
// flipping the code MSB on the way out so comparisons stay monotonic.
// Optional feature: define SAR_SEARCH_TIMEOUT_EN to build a per-probe
// watchdog that aborts with `err` after TIMEOUT unanswered cycles.
module sar_search #(
  parameter int N_WIDTH = 4,
  parameter int SIGNED  = 0,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cmp_valid,
  input  logic               cmp_gt,
  input  logic               cmp_lt,
  input  logic               cmp_eq,
  output logic [N_WIDTH-1:0] probe,
  output logic               probe_valid,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               err,
  output logic [N_WIDTH-1:0] result
);

  localparam int                 IW      = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
  localparam logic [N_WIDTH-1:0] ONE     = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] OFS     = (SIGNED != 0) ? (ONE << (N_WIDTH - 1)) : '0;
  localparam logic [IW-1:0]      IDX_TOP = IW'(N_WIDTH - 1);
  localparam logic [IW-1:0]      IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIAL  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Search code built so far and the bit currently being decided.
  logic [N_WIDTH-1:0] u;
  logic [N_WIDTH-1:0] u_next;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_next;

  // Values the registered outputs take at the next edge.
  logic [N_WIDTH-1:0] probe_next;
  logic               probe_valid_next;
  logic               busy_next;
  logic               done_next;
  logic               found_next;
  logic               err_next;
  logic [N_WIDTH-1:0] result_next;

  logic               in_probe;
  logic               flags_ok;
  logic               bad_flags;
  logic               timeout_hit;
  logic [N_WIDTH-1:0] bit_mask;

  assign in_probe  = (state == TRIAL) || (state == VERIFY);
  assign flags_ok  = $onehot({cmp_gt, cmp_lt, cmp_eq});
  assign bad_flags = in_probe && cmp_valid && !flags_ok;
  assign bit_mask  = ONE << idx;

  // A named scope marks an unusable parameter set in the elaborated hierarchy.
  if ((N_WIDTH < 1) || (TIMEOUT < 1)) begin : g_bad_params
  end

`ifdef SAR_SEARCH_TIMEOUT_EN
  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

  logic [TW-1:0] wait_cnt;

  // The cycle that would bring the count up to TIMEOUT aborts the search.
  assign timeout_hit = in_probe && !cmp_valid && (wait_cnt == WAIT_LAST);

  // Watchdog: count consecutive unanswered cycles of the probe on display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (in_probe && !cmp_valid && !timeout_hit) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: early exit on eq, errors and timeouts go straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = TRIAL;
        end
      end
      TRIAL: begin
        if (timeout_hit || bad_flags || (cmp_valid && cmp_eq)) begin
          state_next = DONE;
        end else if (cmp_valid && (idx == '0)) begin
          state_next = VERIFY;
        end
      end
      VERIFY: begin
        if (timeout_hit || cmp_valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Search datapath: fold each accepted answer into the code and the result flags.
  always_comb begin
    u_next      = u;
    idx_next    = idx;
    result_next = result;
    found_next  = found;
    err_next    = err;
    case (state)
      IDLE: begin
        if (start) begin
          u_next      = '0;
          idx_next    = IDX_TOP;
          result_next = '0;
          found_next  = 1'b0;
          err_next    = 1'b0;
        end
      end
      TRIAL, VERIFY: begin
        if (timeout_hit || bad_flags) begin
          err_next    = 1'b1;
          found_next  = 1'b0;
          result_next = '0;
        end else if (cmp_valid) begin
          if (state == VERIFY) begin
            result_next = probe;
            found_next  = cmp_eq;
          end else if (cmp_eq) begin
            result_next = probe;
            found_next  = 1'b1;
          end else begin
            if (cmp_lt) begin
              u_next = u | bit_mask;
            end
            if (idx != '0) begin
              idx_next = idx - IDX_ONE;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output logic: outputs are prepared for the state being entered, so they register cleanly.
  always_comb begin
    probe_valid_next = (state_next == TRIAL) || (state_next == VERIFY);
    busy_next        = (state_next != IDLE);
    done_next        = (state_next == DONE);
    case (state_next)
      TRIAL:   probe_next = (u_next | (ONE << idx_next)) ^ OFS;
      VERIFY:  probe_next = u_next ^ OFS;
      default: probe_next = '0;
    endcase
  end

  // Datapath and output registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u           <= '0;
      idx         <= '0;
      probe       <= '0;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
    end else begin
      u           <= u_next;
      idx         <= idx_next;
      probe       <= probe_next;
      probe_valid <= probe_valid_next;
      busy        <= busy_next;
      done        <= done_next;
      found       <= found_next;
      err         <= err_next;
      result      <= result_next;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Testbench for sar_search: one unsigned and one signed instance run side by
// side against behavioural comparators; a binary-search reference model
// predicts the probe sequence, result and completion timing.
module tb_sar_search;

  localparam int N   = 4;
  localparam int TMO = 15;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                cmp_valid;
  logic                force_en;
  logic [2:0]          force_flags;
  logic [1:0][N-1:0]   target;

  logic [1:0][N-1:0]   probe;
  logic [1:0][N-1:0]   result;
  logic [1:0]          probe_valid;
  logic [1:0]          busy;
  logic [1:0]          done;
  logic [1:0]          found;
  logic [1:0]          err;
  logic [1:0]          cmp_gt;
  logic [1:0]          cmp_lt;
  logic [1:0]          cmp_eq;

  int check_count = 0;
  int pass_count  = 0;

  int exp_seq [2][8];
  int exp_n   [2];
  int obs_seq [2][8];
  int obs_n   [2];
  int done_cnt[2];
  int done_cyc[2];
  int done_found [2];
  int done_err   [2];
  int done_result[2];

  always #5 clk = ~clk;

  sar_search #(.N_WIDTH(N), .SIGNED(0), .TIMEOUT(TMO)) u_dut_u (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmp_valid  (cmp_valid),
    .cmp_gt     (cmp_gt[0]),
    .cmp_lt     (cmp_lt[0]),
    .cmp_eq     (cmp_eq[0]),
    .probe      (probe[0]),
    .probe_valid(probe_valid[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .found      (found[0]),
    .err        (err[0]),
    .result     (result[0])
  );

  sar_search #(.N_WIDTH(N), .SIGNED(1), .TIMEOUT(TMO)) u_dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmp_valid  (cmp_valid),
    .cmp_gt     (cmp_gt[1]),
    .cmp_lt     (cmp_lt[1]),
    .cmp_eq     (cmp_eq[1]),
    .probe      (probe[1]),
    .probe_valid(probe_valid[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .found      (found[1]),
    .err        (err[1]),
    .result     (result[1])
  );

  // Behavioural comparators (unsigned and signed), with an override for bad flag sets.
  always_comb begin
    cmp_gt    = '0;
    cmp_lt    = '0;
    cmp_eq    = '0;
    cmp_gt[0] = probe[0] > target[0];
    cmp_lt[0] = probe[0] < target[0];
    cmp_eq[0] = probe[0] == target[0];
    cmp_gt[1] = $signed(probe[1]) > $signed(target[1]);
    cmp_lt[1] = $signed(probe[1]) < $signed(target[1]);
    cmp_eq[1] = $signed(probe[1]) == $signed(target[1]);
    if (force_en) begin
      cmp_gt = {2{force_flags[2]}};
      cmp_lt = {2{force_flags[1]}};
      cmp_eq = {2{force_flags[0]}};
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: plain binary search over the ordered value range 0..15.
  task automatic buildExpected(input int k);
    int ord;
    int ofs;
    int lo;
    int trial;
    ofs = (k == 1) ? 8 : 0;
    ord = (k == 1) ? ($signed(target[1]) + 8) : int'(target[0]);
    lo  = 0;
    exp_n[k] = 0;
    for (int b = N - 1; b >= 0; b--) begin
      trial = lo + (1 << b);
      exp_seq[k][exp_n[k]] = (trial - ofs) & 15;
      exp_n[k]++;
      if (trial == ord) return;
      if (trial < ord) lo = trial;
    end
    exp_seq[k][exp_n[k]] = (lo - ofs) & 15;
    exp_n[k]++;
  endtask

  function automatic int allOutputs(input int k);
    return int'({probe[k], probe_valid[k], busy[k], done[k], found[k], err[k], result[k]});
  endfunction

  task automatic applyStimulus(input logic [N-1:0] t0, input logic [N-1:0] t1,
                               input bit rand_valid, input int inject_at,
                               input logic [2:0] inj_flags);
    int  cyc;
    int  gap;
    int  n_cmp;
    bit  finished;
    target[0] = t0;
    target[1] = t1;
    buildExpected(0);
    buildExpected(1);
    for (int k = 0; k < 2; k++) begin
      obs_n[k]    = 0;
      done_cnt[k] = 0;
      done_cyc[k] = 0;
    end
    @(negedge clk);
    start     = 1'b1;
    cmp_valid = 1'b1;
    force_en  = 1'b0;
    cyc       = 0;
    gap       = 0;
    finished  = 1'b0;
    while (!finished && cyc < 80) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (cyc == 1) checkOutput($sformatf("u%0d_cleared_on_start", k), int'({found[k], err[k], result[k]}), 0);
        if (done[k]) begin
          done_cnt[k]++;
          if (done_cyc[k] == 0) begin
            done_cyc[k]    = cyc;
            done_found[k]  = int'(found[k]);
            done_err[k]    = int'(err[k]);
            done_result[k] = int'(result[k]);
          end
        end
      end
      finished = (done_cyc[0] != 0) && (done_cyc[1] != 0) && !busy[0] && !busy[1];
      start = (busy[0] && busy[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rand_valid) begin
        cmp_valid = ($urandom_range(0, 3) != 0) || (gap >= 3);
        gap = cmp_valid ? 0 : gap + 1;
      end
      force_en    = (inject_at == cyc);
      force_flags = inj_flags;
      for (int k = 0; k < 2; k++) begin
        if (probe_valid[k] && cmp_valid && obs_n[k] < 8) begin
          obs_seq[k][obs_n[k]] = int'(probe[k]);
          obs_n[k]++;
        end
      end
    end
    start     = 1'b0;
    cmp_valid = 1'b1;
    force_en  = 1'b0;
    if (!finished) checkOutput("search_finished", 0, 1);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("u%0d_done_pulses", k), done_cnt[k], 1);
      if (inject_at != 0) begin
        checkOutput($sformatf("u%0d_err", k), done_err[k], 1);
        checkOutput($sformatf("u%0d_found_on_err", k), done_found[k], 0);
        checkOutput($sformatf("u%0d_result_on_err", k), done_result[k], 0);
        checkOutput($sformatf("u%0d_err_done_cycle", k), done_cyc[k], inject_at + 1);
        checkOutput($sformatf("u%0d_err_held", k), int'(err[k]), 1);
        n_cmp = inject_at;
      end else begin
        checkOutput($sformatf("u%0d_found", k), done_found[k], 1);
        checkOutput($sformatf("u%0d_err_clear", k), done_err[k], 0);
        checkOutput($sformatf("u%0d_result", k), done_result[k], int'(target[k]));
        checkOutput($sformatf("u%0d_result_held", k), int'(result[k]), int'(target[k]));
        if (!rand_valid) checkOutput($sformatf("u%0d_done_cycle", k), done_cyc[k], exp_n[k] + 1);
        n_cmp = exp_n[k];
      end
      checkOutput($sformatf("u%0d_probe_count", k), obs_n[k], n_cmp);
      for (int i = 0; i < n_cmp && i < obs_n[k]; i++) begin
        checkOutput($sformatf("u%0d_probe%0d", k, i), obs_seq[k][i], exp_seq[k][i]);
      end
      checkOutput($sformatf("u%0d_idle_outputs", k), int'({probe[k], probe_valid[k], busy[k], done[k]}), 0);
    end
  endtask

  task automatic abortMidSearch();
    target[0] = 4'd9;
    target[1] = 4'd6;
    @(negedge clk);
    start     = 1'b1;
    cmp_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) checkOutput($sformatf("u%0d_busy_before_abort", k), int'(busy[k]), 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) checkOutput($sformatf("u%0d_abort_outputs", k), allOutputs(k), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) checkOutput($sformatf("u%0d_after_abort", k), allOutputs(k), 0);
  endtask

  task automatic stallCheck();
    int cyc;
    target[0] = 4'd5;
    target[1] = 4'd5;
    buildExpected(0);
    buildExpected(1);
    for (int k = 0; k < 2; k++) done_cyc[k] = 0;
    @(negedge clk);
    start     = 1'b1;
    cmp_valid = 1'b0;
`ifdef SAR_SEARCH_TIMEOUT_EN
    cyc = 0;
    while (((done_cyc[0] == 0) || (done_cyc[1] == 0)) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (done[k] && done_cyc[k] == 0) begin
          done_cyc[k]  = cyc;
          done_err[k]  = int'(err[k]);
          done_found[k] = int'(found[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("u%0d_timeout_done_cycle", k), done_cyc[k], TMO + 1);
      checkOutput($sformatf("u%0d_timeout_err", k), done_err[k], 1);
      checkOutput($sformatf("u%0d_timeout_found", k), done_found[k], 0);
    end
    @(negedge clk);
`else
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("u%0d_stall_busy", k), int'(busy[k]), 1);
      checkOutput($sformatf("u%0d_stall_probe_valid", k), int'(probe_valid[k]), 1);
      checkOutput($sformatf("u%0d_stall_probe", k), int'(probe[k]), exp_seq[k][0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    cmp_valid = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    cmp_valid   = 1'b0;
    force_en    = 1'b0;
    force_flags = 3'b000;
    target      = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) checkOutput($sformatf("u%0d_reset_state", k), allOutputs(k), 0);
    rst_n = 1'b1;

    $display("[TB] directed searches");
    applyStimulus(4'd11, 4'b1101, 1'b0, 0, 3'b000);
    applyStimulus(4'd0,  4'd7,    1'b0, 0, 3'b000);
    applyStimulus(4'd5,  4'd2,    1'b0, 2, 3'b110);
    applyStimulus(4'd3,  4'd4,    1'b0, 0, 3'b000);
    applyStimulus(4'd0,  4'b1000, 1'b0, 5, 3'b000);

    $display("[TB] reset during search");
    abortMidSearch();
    applyStimulus(4'd9, 4'd6, 1'b0, 0, 3'b000);

    $display("[TB] randomized searches");
    for (int r = 0; r < 20; r++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 0, 3'b000);
    end
    for (int r = 0; r < 4; r++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 0, 3'b000);
    end

    $display("[TB] stalled comparator");
    stallCheck();
    applyStimulus(4'd12, 4'd13, 1'b0, 0, 3'b000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
